rb_frame_scheduler: RTL

//  Sequencing controller for the row-buffer datapath (external fetch, RB write, RB read, steer).
//  Per frame: prefills RB_COUNT rows, then streams the remaining rows, emitting en_E/en_W/en_R,
//  the write-slot select and steer_sel each cycle. Sits between frame-level control and
//  ROW_BUFFER_SYSTEM; applies external-memory and downstream-window backpressure.

---
 rtl/rb_frame_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rb_frame_scheduler
// Brief    : Row-buffer sequencing FSM. Prefills RB_COUNT rows, then streams
//            the rest while emitting fetch/write/read enables and steer rotation.
//            Optional frame counter port: RB_SCHED_FRAME_CNT_EN.
// Revision : 1.0
// ============================================================================
module rb_frame_scheduler #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int KERNEL_SIZE  = 5,
    parameter int RB_COUNT     = KERNEL_SIZE - 1,
    parameter int STALL_CYCLES = 1,
    localparam int SW  = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1,
    localparam int CW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1,
    localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
    localparam int STW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ext_ready,
    input  logic          win_ready,
    output logic          en_E,
    output logic          en_W,
    output logic          en_R,
    output logic [SW-1:0] wr_slot,
    output logic [SW-1:0] steer_sel,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          busy,
    output logic          frame_done
`ifdef RB_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_STREAM  = 3'd2,
        S_STALL   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [STW-1:0]   r_stall_cnt;
    logic             w_adv;
    logic             w_row_end;
    logic             w_last_row;
    logic             w_prefill_last;
    logic             w_stall_end;
    logic [SW-1:0]    w_slot_inc;

    assign w_row_end      = (col == CW'(IMAGE_WIDTH - 1));
    assign w_last_row     = (row == RW'(IMAGE_HEIGHT - 1));
    assign w_prefill_last = (row == RW'(RB_COUNT - 1));
    assign w_stall_end    = (r_stall_cnt == STW'(STALL_CYCLES - 1));
    assign w_slot_inc     = (wr_slot == SW'(RB_COUNT - 1)) ? '0 : wr_slot + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        en_E         = 1'b0;
        en_W         = 1'b0;
        en_R         = 1'b0;
        w_adv        = 1'b0;
        frame_done   = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_PREFILL;
                end
            end
            S_PREFILL: begin
                en_E  = ext_ready;
                en_W  = ext_ready;
                w_adv = ext_ready;
                if (ext_ready && w_row_end) begin
                    if (STALL_CYCLES != 0) begin
                        w_next_state = S_STALL;
                    end else if (w_prefill_last) begin
                        w_next_state = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                w_adv = ext_ready & win_ready;
                en_E  = w_adv;
                en_W  = w_adv;
                en_R  = w_adv;
                if (w_adv && w_row_end) begin
                    if (w_last_row) begin
                        w_next_state = S_DONE;
                    end else if (STALL_CYCLES != 0) begin
                        w_next_state = S_STALL;
                    end
                end
            end
            S_STALL: begin
                // row has already advanced, so it tells which phase resumes
                if (w_stall_end) begin
                    w_next_state = (int'(row) < RB_COUNT) ? S_PREFILL : S_STREAM;
                end
            end
            S_DONE: begin
                frame_done   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            wr_slot   <= '0;
            steer_sel <= '0;
        end else if (r_state == S_DONE) begin
            col       <= '0;
            row       <= '0;
            wr_slot   <= '0;
            steer_sel <= '0;
        end else if (w_adv) begin
            if (w_row_end) begin
                col     <= '0;
                wr_slot <= w_slot_inc;
                if (!(r_state == S_STREAM && w_last_row)) begin
                    row <= row + 1'b1;
                end
                // steer tracks the slot being overwritten only once streaming
                if (r_state == S_STREAM) begin
                    steer_sel <= w_slot_inc;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_STALL && !w_stall_end) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

`ifdef RB_SCHED_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (r_state == S_DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    // frame counter not built in this configuration
`endif

endmodule
`default_nettype wire
